// File: rtl/bin_to_grey.sv
// bin_to_grey: registered binary-to-Gray converter with single-bit-step detection
module bin_to_grey #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] grey_out,
  output logic             out_valid,
  output logic             step_ok
);
  logic [WIDTH-1:0] grey_next;
  logic [WIDTH-1:0] prev_grey;
  logic             have_prev;
  logic             one_bit;
  assign grey_next = bin_in ^ (bin_in >> 1);
  assign one_bit   = $countones(grey_next ^ prev_grey) == 1;
  always_ff @(posedge clk) begin
    if (rst) begin
      grey_out  <= '0;
      out_valid <= 1'b0;
      step_ok   <= 1'b0;
      prev_grey <= '0;
      have_prev <= 1'b0;
    end else begin
      out_valid <= in_valid;
      step_ok   <= in_valid && have_prev && one_bit;
      if (in_valid) begin
        grey_out  <= grey_next;
        prev_grey <= grey_next;
        have_prev <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_grey.sv
// tb_bin_to_grey: table-driven and randomized checks of bin_to_grey at widths 4, 8 and 2
module tb_bin_to_grey;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] bin_in = '0;
  logic [7:0] bin8 = '0;
  logic [1:0] bin2 = '0;
  logic [3:0] grey_out;
  logic [7:0] grey8;
  logic [1:0] grey2;
  logic       out_valid, step_ok, ov8, so8, ov2, so2;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_grey = '0, m_prev = '0;
  logic       m_valid = 1'b0, m_step = 1'b0, m_have = 1'b0;
  logic [7:0] m_g8 = '0;
  logic [1:0] m_g2 = '0;
  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] b;
    logic [3:0] g;
    logic       ov;
    logic       so;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  bin_to_grey #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bin_in(bin_in), .in_valid(in_valid),
    .grey_out(grey_out), .out_valid(out_valid), .step_ok(step_ok));
  bin_to_grey #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bin_in(bin8), .in_valid(in_valid),
    .grey_out(grey8), .out_valid(ov8), .step_ok(so8));
  bin_to_grey #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bin_in(bin2), .in_valid(in_valid),
    .grey_out(grey2), .out_valid(ov2), .step_ok(so2));

  function automatic int bits_set(input logic [3:0] x);
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(x[k]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the reference model.
  task automatic cyc(input logic r, input logic v, input logic [3:0] b,
                     input logic [7:0] b8, input logic [1:0] b2);
    logic [3:0] g;
    rst = r; in_valid = v; bin_in = b; bin8 = b8; bin2 = b2;
    @(posedge clk);
    g = b ^ (b >> 1);
    if (r) begin
      m_grey = '0; m_valid = 0; m_step = 0; m_prev = '0; m_have = 0; m_g8 = '0; m_g2 = '0;
    end else if (v) begin
      m_step = m_have && bits_set(g ^ m_prev) == 1;
      m_grey = g; m_prev = g; m_have = 1; m_valid = 1;
      m_g8 = b8 ^ (b8 >> 1); m_g2 = b2 ^ (b2 >> 1);
    end else begin
      m_valid = 0; m_step = 0;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".grey"}, 32'(grey_out), 32'(m_grey));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".step"}, 32'(step_ok), 32'(m_step));
    chk({tag, ".grey8"}, 32'(grey8), 32'(m_g8));
    chk({tag, ".grey2"}, 32'(grey2), 32'(m_g2));
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] b,
                              input logic [3:0] g, input logic ov, input logic so);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.g = g; t.ov = ov; t.so = so;
    return t;
  endfunction

  initial begin
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0001, 1, 1));
    vecs.push_back(mk(0, 1, 4'b0010, 4'b0011, 1, 1));
    vecs.push_back(mk(0, 1, 4'b0100, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 1, 4'b1001, 4'b1101, 1, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 4'b1111, 1, 1));
    vecs.push_back(mk(0, 1, 4'b1001, 4'b1101, 1, 1));
    vecs.push_back(mk(0, 0, 4'b0111, 4'b1101, 0, 0));
    vecs.push_back(mk(0, 0, 4'b0011, 4'b1101, 0, 0));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b1101, 0, 0));
    vecs.push_back(mk(0, 1, 4'b1000, 4'b1100, 1, 1));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 0));
    cyc(1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].v, vecs[i].b, 8'h00, 2'b00);
      chk($sformatf("vec%0d.grey", i), 32'(grey_out), 32'(vecs[i].g));
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d.step", i), 32'(step_ok), 32'(vecs[i].so));
    end
    // Exhaustive count including 1111 -> 0000 wrap
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i <= 16; i++) begin
      cyc(0, 1, 4'(i), 8'(i), 2'(i));
      chk($sformatf("count%0d", i), 32'(grey_out), 32'(i ^ ((i & 15) >> 1)) & 32'hF);
      chk($sformatf("count%0d.step", i), 32'(step_ok), (i > 0) ? 32'd1 : 32'd0);
      chk_model($sformatf("count%0d", i));
    end
    // Width sweep corners
    cyc(0, 1, 4'b0000, 8'hFF, 2'b10);
    chk("w8.ff", 32'(grey8), 32'h80);
    chk("w2.10", 32'(grey2), 32'h3);
    chk("w8.valid", 32'(ov8), 32'd1);
    chk("w2.valid", 32'(ov2), 32'd1);
    // Randomized traffic with occasional resets and gaps
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
          8'($urandom), 2'($urandom));
      chk_model($sformatf("rand%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
